// File: rtl/win_scoreboard.sv
// Per-player BCD win counter with seven-segment drive and a blinking match-over display.
// A rising edge on win_in adds one win; reaching TARGET freezes the score until clear.
module win_scoreboard #(
    parameter int unsigned NUM_DIGITS    = 2,
    parameter int unsigned TARGET        = 7,
    parameter bit          WRAP          = 1'b0,
    parameter bit          BLANK_LEADING = 1'b1,
    parameter int unsigned BLINK_DIV     = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    win_in,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] score,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    match_over
);

    localparam int unsigned SW = 4 * NUM_DIGITS;

    typedef enum logic {PLAY, OVER} state_t;

    function automatic logic [SW-1:0] to_bcd(input int unsigned v);
        logic [SW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    localparam logic [SW-1:0]        TARGET_BCD = to_bcd(TARGET);
    localparam logic [BLINK_DIV:0]   BLINK_ONE  = {{BLINK_DIV{1'b0}}, 1'b1};

    state_t          state;
    logic            win_q;
    logic            inc;
    logic            hit_target;
    logic [SW-1:0]   score_inc;
    // One extra bit so the MSB toggles every 2**BLINK_DIV cycles (the blink half-period).
    logic [BLINK_DIV:0] blink_cnt;

    assign inc = win_in & ~win_q;

    always_comb begin
        logic carry;
        score_inc = score;
        carry     = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (score[4*k +: 4] == 4'd9) begin
                    score_inc[4*k +: 4] = 4'd0;
                end else begin
                    score_inc[4*k +: 4] = score[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        // Overflow out of the top digit: saturating builds keep all-9s.
        if (carry && !WRAP) begin
            score_inc = score;
        end
    end

    assign hit_target = (TARGET != 0) && (score_inc == TARGET_BCD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score      <= '0;
            win_q      <= 1'b0;
            state      <= PLAY;
            blink_cnt  <= '0;
            match_over <= 1'b0;
        end else begin
            win_q <= win_in;
            if (clear) begin
                score      <= '0;
                state      <= PLAY;
                blink_cnt  <= '0;
                match_over <= 1'b0;
            end else if (state == PLAY) begin
                blink_cnt <= '0;
                if (inc) begin
                    score <= score_inc;
                    if (hit_target) begin
                        state      <= OVER;
                        match_over <= 1'b1;
                    end
                end
            end else begin
                blink_cnt <= blink_cnt + BLINK_ONE;
            end
        end
    end

    always_comb begin
        logic        higher_nz;
        logic        blank_all;
        logic [3:0]  digit;
        int unsigned k;
        hex_out   = '1;
        higher_nz = 1'b0;
        blank_all = (state == OVER) && blink_cnt[BLINK_DIV];
        digit     = '0;
        k         = 0;
        // Walk from the most significant digit so leading-zero status is known per digit.
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            k         = NUM_DIGITS - 1 - i;
            digit     = score[4*k +: 4];
            higher_nz = higher_nz | (digit != 4'd0);
            if (blank_all || (BLANK_LEADING && (k != 0) && !higher_nz)) begin
                hex_out[7*k +: 7] = 7'b1111111;
            end else begin
                hex_out[7*k +: 7] = seg(digit);
            end
        end
    end

endmodule

// File: tb/tb_win_scoreboard.sv
// Directed bench for win_scoreboard: expected values queued on a scoreboard and popped at each check.
module tb_win_scoreboard;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;
    localparam logic [6:0] H7 = 7'b1111000;
    localparam logic [6:0] H9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        win_a, clear_a, win_b, clear_b;
    logic [7:0]  score_a, score_b;
    logic [13:0] hex_a, hex_b;
    logic [3:0]  score_s, score_w;
    logic [6:0]  hex_s, hex_w;
    logic        over_a, over_b, over_s, over_w;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    win_scoreboard #(.NUM_DIGITS(2), .TARGET(7), .WRAP(1'b0), .BLANK_LEADING(1'b1), .BLINK_DIV(2)) u_a (
        .clk(clk), .reset(reset), .win_in(win_a), .clear(clear_a),
        .score(score_a), .hex_out(hex_a), .match_over(over_a));

    win_scoreboard #(.NUM_DIGITS(2), .TARGET(0), .WRAP(1'b0), .BLANK_LEADING(1'b1), .BLINK_DIV(2)) u_b (
        .clk(clk), .reset(reset), .win_in(win_b), .clear(clear_b),
        .score(score_b), .hex_out(hex_b), .match_over(over_b));

    win_scoreboard #(.NUM_DIGITS(1), .TARGET(0), .WRAP(1'b0), .BLANK_LEADING(1'b1), .BLINK_DIV(2)) u_s (
        .clk(clk), .reset(reset), .win_in(win_b), .clear(clear_b),
        .score(score_s), .hex_out(hex_s), .match_over(over_s));

    win_scoreboard #(.NUM_DIGITS(1), .TARGET(0), .WRAP(1'b1), .BLANK_LEADING(1'b1), .BLINK_DIV(2)) u_w (
        .clk(clk), .reset(reset), .win_in(win_b), .clear(clear_b),
        .score(score_w), .hex_out(hex_w), .match_over(over_w));

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_item_t it;
        it.tag = tag;
        it.exp = v;
        sb.push_back(it);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_item_t it;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL sb_empty observed=%h expected=<queued value>", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
        expect_val(tag, v);
        check(obs);
    endtask

    task automatic exp_a(input string t, input logic [7:0] s, input logic [13:0] h, input logic m);
        expect_val({t, "_score"}, 32'(s));
        expect_val({t, "_hex"}, 32'(h));
        expect_val({t, "_over"}, 32'(m));
    endtask

    task automatic pop_a();
        check(32'(score_a));
        check(32'(hex_a));
        check(32'(over_a));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        win_a = 1'b1;
        step();
        win_a = 1'b0;
        step();
    endtask

    task automatic pulse_b();
        win_b = 1'b1;
        step();
        win_b = 1'b0;
        step();
    endtask

    initial begin
        reset   = 1'b1;
        win_a   = 1'b0;
        clear_a = 1'b0;
        win_b   = 1'b0;
        clear_b = 1'b0;
        #1;
        exp_a("reset", 8'h00, {BL, H0}, 1'b0);
        pop_a();
        repeat (2) step();
        reset = 1'b0;

        // Level held high counts once; a later rising edge counts again.
        win_a = 1'b1;
        exp_a("edge_first", 8'h01, {BL, H1}, 1'b0);
        repeat (5) step();
        pop_a();
        win_a = 1'b0;
        repeat (3) step();
        win_a = 1'b1;
        step();
        win_a = 1'b0;
        exp_a("edge_count", 8'h02, {BL, H2}, 1'b0);
        step();
        pop_a();

        // Reach TARGET=7, then watch the blink pattern and the ignored 8th win.
        repeat (4) pulse_a();
        win_a = 1'b1;
        exp_a("over_entry", 8'h07, {BL, H7}, 1'b1);
        step();
        pop_a();
        for (int i = 1; i < 12; i++) begin
            win_a = (i == 2) ? 1'b1 : 1'b0;
            expect_val("blink_hex", 32'(((i % 8) < 4) ? {BL, H7} : 14'h3FFF));
            step();
            check(32'(hex_a));
        end
        win_a = 1'b0;
        chk("over_hold_score", 32'(score_a), 32'h07);
        chk("over_hold_flag", 32'(over_a), 32'h1);

        // Clear out of OVER gives a steady "0".
        clear_a = 1'b1;
        exp_a("clr_over", 8'h00, {BL, H0}, 1'b0);
        step();
        clear_a = 1'b0;
        pop_a();
        for (int i = 0; i < 5; i++) begin
            exp_a("clr_steady", 8'h00, {BL, H0}, 1'b0);
            step();
            pop_a();
        end

        // Clear and win arriving together: the win is dropped.
        repeat (3) pulse_a();
        chk("pre_race_score", 32'(score_a), 32'h03);
        chk("pre_race_hex", 32'(hex_a), 32'({BL, H3}));
        clear_a = 1'b1;
        win_a   = 1'b1;
        exp_a("race", 8'h00, {BL, H0}, 1'b0);
        step();
        pop_a();
        clear_a = 1'b0;
        exp_a("race_hold", 8'h00, {BL, H0}, 1'b0);
        step();
        pop_a();
        win_a = 1'b0;
        step();
        pulse_a();
        exp_a("after_race", 8'h01, {BL, H1}, 1'b0);
        pop_a();

        // Carry, blanking, saturate and wrap on the TARGET=0 instances.
        repeat (10) pulse_b();
        chk("carry_score", 32'(score_b), 32'h10);
        chk("carry_hex", 32'(hex_b), 32'({H1, H0}));
        chk("carry_over", 32'(over_b), 32'h0);
        chk("sat10_score", 32'(score_s), 32'h9);
        chk("sat10_hex", 32'(hex_s), 32'(H9));
        chk("wrap10_score", 32'(score_w), 32'h0);
        chk("wrap10_hex", 32'(hex_w), 32'(H0));
        pulse_b();
        chk("count11_score", 32'(score_b), 32'h11);
        chk("count11_hex", 32'(hex_b), 32'({H1, H1}));
        chk("sat11_score", 32'(score_s), 32'h9);
        chk("sat11_over", 32'(over_s), 32'h0);
        chk("wrap11_score", 32'(score_w), 32'h1);
        chk("wrap11_hex", 32'(hex_w), 32'(H1));
        chk("wrap11_over", 32'(over_w), 32'h0);

        // Asynchronous reset in the middle of a clock period.
        repeat (2) pulse_a();
        chk("pre_reset_score", 32'(score_a), 32'h03);
        #3;
        reset = 1'b1;
        #1;
        exp_a("mid_reset", 8'h00, {BL, H0}, 1'b0);
        pop_a();
        chk("mid_reset_b_score", 32'(score_b), 32'h00);
        chk("mid_reset_b_hex", 32'(hex_b), 32'({BL, H0}));
        chk("mid_reset_s_score", 32'(score_s), 32'h0);
        chk("mid_reset_w_score", 32'(score_w), 32'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
